// File: rtl/ones_pattern_gen.sv
// Bit-serial generator: builds a 16-bit word holding exactly min(count,16) ones,
// one bit per clock LSB-first, as an LSB/MSB thermometer or evenly spread.
module ones_pattern_gen #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       count,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] pattern,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_BUILD, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    idx, idx_nxt;
  logic [4:0]       acc, acc_nxt;
  logic [4:0]       n_q, n_nxt;
  logic [1:0]       mode_q, mode_nxt;
  logic [WIDTH-1:0] pattern_nxt;
  logic             bit_out_nxt, bit_valid_nxt, busy_nxt, done_nxt, err_nxt;

  logic [4:0]       sum, acc_step, thr, idx_ext;
  logic             b;

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      acc       <= '0;
      n_q       <= '0;
      mode_q    <= '0;
      pattern   <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      acc       <= acc_nxt;
      n_q       <= n_nxt;
      mode_q    <= mode_nxt;
      pattern   <= pattern_nxt;
      bit_out   <= bit_out_nxt;
      bit_valid <= bit_valid_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_BUILD;
      S_BUILD: if (idx == IW'(WIDTH - 1)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bit rule; the spread mode is a 16-modulus accumulator overflowing n times per word
  always_comb begin
    idx_ext  = {{(5 - IW){1'b0}}, idx};
    sum      = acc + n_q;
    acc_step = (sum >= 5'd16) ? sum - 5'd16 : sum;
    thr      = 5'd16 - n_q;
    case (mode_q)
      2'b01:   b = (idx_ext >= thr);
      2'b10:   b = (sum >= 5'd16);
      default: b = (idx_ext < n_q);
    endcase
  end

  // Output / datapath logic
  always_comb begin
    idx_nxt       = idx;
    acc_nxt       = acc;
    n_nxt         = n_q;
    mode_nxt      = mode_q;
    pattern_nxt   = pattern;
    bit_out_nxt   = bit_out;
    bit_valid_nxt = 1'b0;
    done_nxt      = 1'b0;
    err_nxt       = err;
    case (state)
      S_IDLE: begin
        if (start) begin
          n_nxt       = (count > 5'd16) ? 5'd16 : count;
          mode_nxt    = mode;
          pattern_nxt = '0;
          idx_nxt     = '0;
          acc_nxt     = '0;
          err_nxt     = (count > 5'd16);
        end
      end
      S_BUILD: begin
        pattern_nxt[idx] = b;
        bit_out_nxt      = b;
        bit_valid_nxt    = 1'b1;
        idx_nxt          = idx + 1'b1;
        acc_nxt          = acc_step;
      end
      S_DONE: done_nxt = 1'b1;
      default: ;
    endcase
    // Stay busy through the DONE pulse; a start on the following edge is accepted
    busy_nxt = (state_nxt != S_IDLE) || (state == S_DONE);
  end

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Directed bench for ones_pattern_gen: per-edge checks of the serial stream,
// done/busy timing, clamping, sticky err, back-to-back starts and mid-run reset.
module tb_ones_pattern_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  count;
  logic [1:0]  mode;
  logic [15:0] pattern;
  logic        bit_out, bit_valid, busy, done, err;

  int tests = 0;
  int fails = 0;

  ones_pattern_gen #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .count(count), .mode(mode),
    .pattern(pattern), .bit_out(bit_out), .bit_valid(bit_valid),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent reference: spread mode sets bit k when floor(k*n/16) steps up
  function automatic logic [15:0] model(input logic [4:0] cnt, input logic [1:0] md);
    int n;
    logic [15:0] p;
    n = (cnt > 16) ? 16 : int'(cnt);
    p = '0;
    for (int k = 0; k < 16; k++) begin
      case (md)
        2'b01:   p[k] = (k >= 16 - n);
        2'b10:   p[k] = (((k + 1) * n) / 16) != ((k * n) / 16);
        default: p[k] = (k < n);
      endcase
    end
    return p;
  endfunction

  function automatic int popc(input logic [15:0] p);
    int c = 0;
    for (int k = 0; k < 16; k++) c += int'(p[k]);
    return c;
  endfunction

  // Full request from edge 0 to edge 18, checked after every edge
  task automatic run_req(input logic [4:0] cnt, input logic [1:0] md, input logic [15:0] exp_pat);
    logic e_err;
    e_err = (cnt > 5'd16);
    start = 1'b1; count = cnt; mode = md;
    @(posedge clk); #1;
    start = 1'b0; count = ~cnt; mode = ~md;  // post-accept changes must not matter
    chk("acc_busy", busy, 1);
    chk("acc_pattern_clear", pattern, 0);
    chk("acc_bit_valid", bit_valid, 0);
    chk("acc_err", err, e_err);
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      chk("bit_valid", bit_valid, 1);
      chk("bit_out", bit_out, exp_pat[k-1]);
      chk("done_early", done, 0);
    end
    @(posedge clk); #1;
    chk("done_pulse", done, 1);
    chk("done_bit_valid", bit_valid, 0);
    chk("done_busy", busy, 1);
    chk("final_pattern", pattern, exp_pat);
    chk("popcount", popc(pattern), (cnt > 5'd16) ? 16 : int'(cnt));
    chk("err_hold", err, e_err);
    @(posedge clk); #1;
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("pattern_hold", pattern, exp_pat);
  endtask

  initial begin
    logic [4:0] rc;
    logic [1:0] rm;
    bit seen;
    reset = 1'b1; start = 1'b0; count = '0; mode = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pattern", pattern, 0);
    chk("rst_outs", {bit_out, bit_valid, busy, done, err}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_req(5'd5,  2'b00, 16'h001F);
    run_req(5'd3,  2'b01, 16'hE000);
    run_req(5'd4,  2'b10, 16'h8888);
    run_req(5'd5,  2'b10, 16'h9248);
    run_req(5'd16, 2'b10, 16'hFFFF);
    run_req(5'd20, 2'b10, 16'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    chk("err_sticky_idle", err, 1);
    run_req(5'd2,  2'b00, 16'h0003);
    run_req(5'd0,  2'b00, 16'h0000);
    run_req(5'd0,  2'b10, 16'h0000);
    run_req(5'd0,  2'b01, 16'h0000);
    run_req(5'd9,  2'b11, 16'h01FF);
    run_req(5'd16, 2'b01, 16'hFFFF);

    // start held high: accepts at 0,18,36 and done at 17,35,53
    start = 1'b1; count = 5'd7; mode = 2'b00;
    for (int e = 0; e < 54; e++) begin
      @(posedge clk); #1;
      chk("b2b_done", done, (e % 18) == 17);
      chk("b2b_busy", busy, 1);
      if ((e % 18) == 0) chk("b2b_accept_clear", pattern, 0);
      if ((e % 18) == 17) chk("b2b_pattern", pattern, 16'h007F);
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk("b2b_idle", busy, 0);

    // reset at edge 8 of a mode-00 count-16 request
    start = 1'b1; count = 5'd16; mode = 2'b00;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("pre_rst_pattern", pattern, 16'h007F);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_pattern", pattern, 0);
    chk("midrst_outs", {bit_out, bit_valid, busy, done, err}, 0);
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    chk("midrst_no_done", seen, 0);
    run_req(5'd11, 2'b00, 16'h07FF);

    for (int i = 0; i < 8; i++) begin
      rc = 5'($urandom_range(31, 0));
      rm = 2'($urandom_range(3, 0));
      run_req(rc, rm, model(rc, rm));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ones_pattern_gen.md
# ones_pattern_gen

Bit-serial generator that builds a 16-bit word containing exactly a requested number of 1s. It is the inverse of the team's serial ones-counter: one bit is produced per clock, in LSB-first order, under one of three placement modes. It serves as the stimulus/pattern source for population-count datapaths and as a self-consistency partner for them: the population count of `pattern` must equal the clamped request.

## Interface
- `WIDTH`, 16, word width. Only 16 is supported.
- `clk`, in, 1, rising-edge clock.
- `reset`, in, 1, synchronous, active-high.
- `start`, in, 1, request strobe; sampled only while `busy`=0.
- `count`, in, 5, requested number of 1s; legal range 0..16.
- `mode`, in, 2, placement mode:
  - 00: thermometer from the LSB.
  - 01: thermometer from the MSB.
  - 10: evenly spread.
  - 11: reserved; behaves as 00.
- `pattern`, out, 16, word under construction; final once `done` is seen.
- `bit_out`, out, 1, the bit just generated.
- `bit_valid`, out, 1, `bit_out` is meaningful this cycle.
- `busy`, out, 1, generation in progress; `start` is ignored.
- `done`, out, 1, one-cycle pulse; `pattern` is complete.
- `err`, out, 1, the last accepted `count` exceeded 16 and was clamped.

## Operation
- Reset values: `pattern`=0, `bit_out`=0, `bit_valid`=0, `busy`=0, `done`=0, `err`=0, state IDLE, `idx`=0, `acc`=0.
- All outputs are registered.
- State machine: IDLE -> BUILD -> DONE -> IDLE.
- **IDLE**, on `start`=1 (accept):
  - Latch `n` = min(`count`, 16) and `mode`.
  - Clear `pattern`, set `idx`=0, `acc`=0.
  - Set `err` = (`count` > 16).
  - Go to BUILD.
- **BUILD**: one bit per cycle for `idx` = 0..15.
  - Bit rule, mode 00: `b` = (`idx` < `n`).
  - Bit rule, mode 01: `b` = (`idx` >= 16 − `n`).
  - Bit rule, mode 10, using a 5-bit accumulator: `s` = `acc` + `n`. If `s` >= 16 then `b`=1 and `acc` <= `s` − 16; else `b`=0 and `acc` <= `s`.
  - Each cycle: `pattern[idx]` <= `b`, `bit_out` <= `b`, `bit_valid` <= 1, `idx` <= `idx`+1.
  - After `idx`=15, go to DONE.
- **DONE**: `done`=1, `bit_valid`=0. Next state IDLE.
- Invariant: popcount(`pattern`) = `n` in every mode.
- Mode 10 with `n`=0 yields all 0s; with `n`=16 it yields all 1s.
- `err` is sticky until the next accepted `start` or `reset`.
- `pattern` holds its final value until the next accept.
- `start` during BUILD or DONE is ignored. It is not queued.
- Changes to `count`/`mode` after accept have no effect.
- `reset` has priority over everything. Asserted mid-BUILD or in DONE, all outputs return to reset values on that edge, and no `done` is issued for the aborted request.

## Timing
- Edge 0: `start` is accepted.
  - After edge 0: `busy`=1, `pattern`=0, `err` is valid, `bit_valid`=0.
- Edges 1..16: bit `k−1` is generated.
  - After edge `k`: `bit_valid`=1, `bit_out`=`pattern[k−1]`.
- Edge 17: enter DONE.
  - After edge 17: `done`=1, `bit_valid`=0, `busy`=1, `pattern` is final.
- Edge 18: return to IDLE.
  - After edge 18: `done`=0, `busy`=0.
  - A new `start` may be sampled at edge 18.
- Request-to-done latency: 17 cycles.
- Throughput: one word per 18 cycles.
- `count`=0 still takes the full 18 cycles and still pulses `done`.

## Test plan
- Mode 00, `count`=5: `bit_out` stream is 1,1,1,1,1 followed by eleven 0s; `pattern`=0x001F at `done`; `done` at edge 17; `err`=0.
- Mode 01, `count`=3 gives `pattern`=0xE000. Mode 10, `count`=4 gives 0x8888. Mode 10, `count`=5 gives 0x9248. Mode 10, `count`=16 gives 0xFFFF.
- Mode 10, `count`=20: clamped; `pattern`=0xFFFF, `err`=1 from edge 0 until the next accept. A following request with `count`=2 clears `err`.
- `count`=0, any mode: `pattern`=0x0000, `bit_valid` is high for exactly 16 cycles, and `done` pulses once at edge 17.
- `start` held high continuously with `count`=7: requests are accepted at edges 0, 18, 36, …; `done` pulses at 17, 35, …; no accept occurs while `busy`=1.
- `reset` asserted at edge 8 of a mode 00, `count`=16 request: all outputs are 0 after that edge and no `done` is issued. A new request is then accepted normally.
- Random sweep over `count` and `mode`: popcount(`pattern`) = min(`count`, 16) for every request.
